// File: rtl/sprite_renderer_if.sv
// Sprite renderer bus: timing-generator coordinates, position writes, sprite ROM port and mux outputs.
// Latency: none (wiring only).
// Backpressure: none; every signal is sampled or driven on each pixel clock.
interface sprite_renderer_if #(
  parameter int ADDR_W = 8
);
  logic [9:0]        pixel_x;
  logic [9:0]        pixel_y;
  logic              video_on;
  logic              frame_start;
  logic [9:0]        pos_x_in;
  logic [9:0]        pos_y_in;
  logic              pos_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_data;
  logic [11:0]       sprite_colour;
  logic              sprite_sel;

  // Master side: timing generator, CPU position port and sprite ROM.
  modport master (
    output pixel_x, pixel_y, video_on, frame_start,
    output pos_x_in, pos_y_in, pos_we, rom_data,
    input  rom_addr, sprite_colour, sprite_sel
  );

  // Slave side: the renderer itself.
  modport slave (
    input  pixel_x, pixel_y, video_on, frame_start,
    input  pos_x_in, pos_y_in, pos_we, rom_data,
    output rom_addr, sprite_colour, sprite_sel
  );
endinterface

// File: rtl/sprite_renderer.sv
// Single-sprite overlay: hit test against a double-buffered position, ROM fetch, transparency key.
// Latency: 2 clk from pixel coordinates to sprite_sel/sprite_colour.
// Backpressure: none; one pixel per clock, position updates take effect only at frame_start.
module sprite_renderer #(
  parameter int          SPRITE_W    = 16,
  parameter int          SPRITE_H    = 16,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input logic              clk,
  input logic              rst,
  sprite_renderer_if.slave bus
);
  localparam int XW     = $clog2(SPRITE_W);
  localparam int YW     = $clog2(SPRITE_H);
  localparam int ADDR_W = XW + YW;

  logic [9:0]        act_x, act_y;
  logic [9:0]        pend_x, pend_y;
  logic              pend_valid;
  logic              hit, hit_d1, hit_d2;
  logic [10:0]       x_end, y_end;
  logic [XW-1:0]     off_x;
  logic [YW-1:0]     off_y;
  logic [ADDR_W-1:0] rom_addr_q;

  // Position double buffer: writes land in pending and move to active only on frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_x      <= '0;
      act_y      <= '0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_valid <= 1'b0;
    end else if (bus.frame_start) begin
      // A write coinciding with frame_start goes straight to active.
      if (bus.pos_we) begin
        act_x <= bus.pos_x_in;
        act_y <= bus.pos_y_in;
      end else if (pend_valid) begin
        act_x <= pend_x;
        act_y <= pend_y;
      end
      pend_valid <= 1'b0;
    end else if (bus.pos_we) begin
      pend_x     <= bus.pos_x_in;
      pend_y     <= bus.pos_y_in;
      pend_valid <= 1'b1;
    end
  end

  // Stage 0: hit test with 11-bit right/bottom edges so the sprite clips at 1023 rather than wrapping.
  always_comb begin
    x_end = {1'b0, act_x} + 11'(SPRITE_W);
    y_end = {1'b0, act_y} + 11'(SPRITE_H);
    hit   = bus.video_on
          && (bus.pixel_x >= act_x) && ({1'b0, bus.pixel_x} < x_end)
          && (bus.pixel_y >= act_y) && ({1'b0, bus.pixel_y} < y_end);
    // Offsets are below the sprite size, so the low bits of the difference are enough.
    off_x = bus.pixel_x[XW-1:0] - act_x[XW-1:0];
    off_y = bus.pixel_y[YW-1:0] - act_y[YW-1:0];
  end

  // Stage 1: register ROM address (row-major, width is a power of two) and the hit flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= '0;
      hit_d1     <= 1'b0;
    end else begin
      rom_addr_q <= hit ? {off_y, off_x} : '0;
      hit_d1     <= hit;
    end
  end

  // Stage 2: align the hit flag with the colour returned by the ROM.
  always_ff @(posedge clk) begin
    if (rst) hit_d2 <= 1'b0;
    else     hit_d2 <= hit_d1;
  end

  // Output mux control: transparent texels and reset both fall through to background.
  always_comb begin
    bus.sprite_sel    = hit_d2 && !rst && (bus.rom_data != TRANSPARENT);
    bus.sprite_colour = bus.sprite_sel ? bus.rom_data : 12'h000;
  end

  assign bus.rom_addr = rom_addr_q;
endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: hit/latency, edges, transparency, double buffer, clipping, reset.
// Latency checked: rom_addr one clock after the pixel, sel/colour two clocks after.
// Backpressure: none in the design; stimulus is one directed step per clock.
module tb_sprite_renderer;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  sprite_renderer_if #(.ADDR_W(8)) bif ();

  sprite_renderer #(
    .SPRITE_W(16), .SPRITE_H(16), .TRANSPARENT(12'hF0F)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle position port operation.
  task automatic set_pos(input logic [9:0] x, input logic [9:0] y, input logic we, input logic fs);
    bif.pos_x_in    = x;
    bif.pos_y_in    = y;
    bif.pos_we      = we;
    bif.frame_start = fs;
    step();
    bif.pos_we      = 1'b0;
    bif.frame_start = 1'b0;
  endtask

  // Present one pixel, check rom_addr after 1 clock and sel/colour after 2.
  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y, input logic von,
                     input logic [7:0] exp_addr, input logic exp_sel, input logic [11:0] exp_col);
    bif.pixel_x  = x;
    bif.pixel_y  = y;
    bif.video_on = von;
    step();
    chk({tag, "_addr"}, 32'(bif.rom_addr), 32'(exp_addr));
    bif.video_on = 1'b0;
    step();
    chk({tag, "_sel"}, 32'(bif.sprite_sel), 32'(exp_sel));
    chk({tag, "_col"}, 32'(bif.sprite_colour), 32'(exp_col));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst              = 1'b1;
    bif.pixel_x      = '0;
    bif.pixel_y      = '0;
    bif.video_on     = 1'b0;
    bif.frame_start  = 1'b0;
    bif.pos_x_in     = '0;
    bif.pos_y_in     = '0;
    bif.pos_we       = 1'b0;
    bif.rom_data     = 12'h0F0;

    // Reset state
    step();
    step();
    chk("rst_sel", 32'(bif.sprite_sel), 32'd0);
    chk("rst_col", 32'(bif.sprite_colour), 32'h000);
    chk("rst_addr", 32'(bif.rom_addr), 32'd0);
    chk("rst_pend", 32'(dut.pend_valid), 32'd0);
    rst = 1'b0;
    chk("post_rst_sel", 32'(bif.sprite_sel), 32'd0);

    // Load active (100,50) with write + frame_start together
    set_pos(10'd100, 10'd50, 1'b1, 1'b1);
    chk("load_act_x", 32'(dut.act_x), 32'd100);
    chk("load_act_y", 32'(dut.act_y), 32'd50);
    chk("load_pend", 32'(dut.pend_valid), 32'd0);

    // Hit / latency and edges
    pix("hit_tl", 10'd100, 10'd50, 1'b1, 8'd0, 1'b1, 12'h0F0);
    pix("hit_br", 10'd115, 10'd65, 1'b1, 8'd255, 1'b1, 12'h0F0);
    pix("miss_r", 10'd116, 10'd50, 1'b1, 8'd0, 1'b0, 12'h000);
    pix("miss_l", 10'd99, 10'd50, 1'b1, 8'd0, 1'b0, 12'h000);
    pix("miss_b", 10'd100, 10'd66, 1'b1, 8'd0, 1'b0, 12'h000);
    pix("blank", 10'd100, 10'd50, 1'b0, 8'd0, 1'b0, 12'h000);

    // Transparency: (105,55) -> offset (5,5) -> address 85
    bif.rom_data = 12'hF0F;
    pix("transp", 10'd105, 10'd55, 1'b1, 8'd85, 1'b0, 12'h000);
    bif.rom_data = 12'h0F0;

    // Double buffer: mid-frame writes stay pending, last one wins
    set_pos(10'd300, 10'd400, 1'b1, 1'b0);
    set_pos(10'd200, 10'd300, 1'b1, 1'b0);
    chk("mid_act_x", 32'(dut.act_x), 32'd100);
    chk("mid_act_y", 32'(dut.act_y), 32'd50);
    chk("mid_pend", 32'(dut.pend_valid), 32'd1);
    pix("mid_hit", 10'd100, 10'd50, 1'b1, 8'd0, 1'b1, 12'h0F0);
    set_pos(10'd0, 10'd0, 1'b0, 1'b1);
    chk("fs_act_x", 32'(dut.act_x), 32'd200);
    chk("fs_act_y", 32'(dut.act_y), 32'd300);
    chk("fs_pend", 32'(dut.pend_valid), 32'd0);
    set_pos(10'd5, 10'd5, 1'b0, 1'b1);
    chk("fs_nopend_x", 32'(dut.act_x), 32'd200);
    chk("fs_nopend_y", 32'(dut.act_y), 32'd300);
    // (203,301) -> offset (3,1) -> address 19
    pix("new_hit", 10'd203, 10'd301, 1'b1, 8'd19, 1'b1, 12'h0F0);
    set_pos(10'd10, 10'd10, 1'b1, 1'b1);
    chk("same_act_x", 32'(dut.act_x), 32'd10);
    chk("same_act_y", 32'(dut.act_y), 32'd10);
    chk("same_pend", 32'(dut.pend_valid), 32'd0);

    // Clipping at the right edge of the screen
    set_pos(10'd1020, 10'd0, 1'b1, 1'b1);
    pix("clip_hit", 10'd1023, 10'd0, 1'b1, 8'd3, 1'b1, 12'h0F0);
    pix("clip_nowrap", 10'd0, 10'd0, 1'b1, 8'd0, 1'b0, 12'h000);
    pix("clip_left", 10'd1019, 10'd0, 1'b1, 8'd0, 1'b0, 12'h000);

    // Reset mid-operation with a pending write and a hit in flight
    set_pos(10'd100, 10'd50, 1'b1, 1'b1);
    set_pos(10'd7, 10'd7, 1'b1, 1'b0);
    bif.pixel_x  = 10'd100;
    bif.pixel_y  = 10'd50;
    bif.video_on = 1'b1;
    step();
    step();
    chk("pre_rst_sel", 32'(bif.sprite_sel), 32'd1);
    rst = 1'b1;
    #1;
    chk("in_rst_sel", 32'(bif.sprite_sel), 32'd0);
    step();
    chk("mrst_sel", 32'(bif.sprite_sel), 32'd0);
    chk("mrst_col", 32'(bif.sprite_colour), 32'h000);
    chk("mrst_act_x", 32'(dut.act_x), 32'd0);
    chk("mrst_act_y", 32'(dut.act_y), 32'd0);
    chk("mrst_pend", 32'(dut.pend_valid), 32'd0);
    chk("mrst_addr", 32'(bif.rom_addr), 32'd0);
    rst = 1'b0;
    bif.video_on = 1'b0;
    set_pos(10'd0, 10'd0, 1'b0, 1'b1);
    chk("discard_x", 32'(dut.act_x), 32'd0);
    chk("discard_y", 32'(dut.act_y), 32'd0);

    // Reset priority over a simultaneous write + frame_start
    rst = 1'b1;
    set_pos(10'd33, 10'd44, 1'b1, 1'b1);
    rst = 1'b0;
    chk("rstprio_x", 32'(dut.act_x), 32'd0);
    chk("rstprio_pend", 32'(dut.pend_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
